// File: rtl/picmicro_periph_pkg.sv
// Shared address map, T1CON field layout and prescaler helpers for the bank-0 timer peripherals.
// Constants only; no latency or flow control of its own.
package picmicro_periph_pkg;

  localparam logic [8:0] ADDR_TMR1L = 9'h00E;
  localparam logic [8:0] ADDR_TMR1H = 9'h00F;
  localparam logic [8:0] ADDR_T1CON = 9'h010;

  localparam int T1CON_TMR1ON    = 0;
  localparam int T1CON_TMR1CS    = 1;
  localparam int T1CON_T1SYNC    = 2;
  localparam int T1CON_T1OSCEN   = 3;
  localparam int T1CON_T1CKPS_LO = 4;
  localparam int T1CON_T1CKPS_HI = 5;
  localparam int T1CON_W         = 6;

  localparam int PIR1_TMR1IF = 0;

  typedef enum logic [1:0] {
    T1CKPS_1 = 2'd0,
    T1CKPS_2 = 2'd1,
    T1CKPS_4 = 2'd2,
    T1CKPS_8 = 2'd3
  } t1ckps_e;

  // Last prescaler count before the counter advances (ratio - 1).
  function automatic logic [2:0] psc_terminal(input t1ckps_e ckps);
    case (ckps)
      T1CKPS_1: return 3'd0;
      T1CKPS_2: return 3'd1;
      T1CKPS_4: return 3'd3;
      default:  return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Optional N-flop synchroniser followed by a rising-edge detector producing a one-clk pulse.
// Latency: SYNC_STAGES clk edges to the pulse; no backpressure, runs every cycle.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic w_sync;
  logic r_prev;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_sync = i_sig;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= i_sig;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
          end
        end
      end

      assign w_sync = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_sync;
    end
  end

  assign o_rise = w_sync & ~r_prev;

endmodule

// File: rtl/timer1_peripheral.sv
// 16-bit Timer1 with 1/2/4/8 prescaler, clkout or T1CKI source, and a one-clk wrap strobe for TMR1IF.
// Latency: counter updates 1 clk after a clkout rise, 3 clks after a T1CKI rise; reads are combinational; no backpressure.
module timer1_peripheral
  import picmicro_periph_pkg::*;
#(
  parameter logic [8:0] BASE_TMR1L = ADDR_TMR1L
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clkout,
  input  logic       t1cki,
  input  logic [8:0] addr,
  input  logic [7:0] data_in,
  input  logic       wr_en,
  output logic [7:0] data_out,
  output logic       rd_hit,
  output logic       tmr1if_strobe
);

  logic [15:0]        r_tmr1;
  logic [T1CON_W-1:0] r_t1con;
  logic [2:0]         r_psc;
  logic               r_strobe;

  logic w_sel_l, w_sel_h, w_sel_c;
  logic w_wr_l, w_wr_h, w_wr_c, w_wr_tmr;
  logic w_clk_rise, w_t1_rise;
  logic w_tick, w_inc_en, w_psc_hit, w_tmr_inc;

  assign w_sel_l  = (addr == BASE_TMR1L);
  assign w_sel_h  = (addr == BASE_TMR1L + 9'd1);
  assign w_sel_c  = (addr == BASE_TMR1L + 9'd2);
  assign w_wr_l   = wr_en & w_sel_l;
  assign w_wr_h   = wr_en & w_sel_h;
  assign w_wr_c   = wr_en & w_sel_c;
  assign w_wr_tmr = w_wr_l | w_wr_h;

  // Both detectors always run so enabling or switching source cannot fabricate an edge.
  sync_edge_detect #(.SYNC_STAGES(0)) u_clkout_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sig  (clkout),
    .o_rise (w_clk_rise)
  );

  sync_edge_detect #(.SYNC_STAGES(2)) u_t1cki_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sig  (t1cki),
    .o_rise (w_t1_rise)
  );

  assign w_tick    = r_t1con[T1CON_TMR1CS] ? w_t1_rise : w_clk_rise;
  assign w_inc_en  = w_tick & r_t1con[T1CON_TMR1ON];
  assign w_psc_hit = (r_psc == psc_terminal(t1ckps_e'(r_t1con[T1CON_T1CKPS_HI:T1CON_T1CKPS_LO])));
  assign w_tmr_inc = w_inc_en & w_psc_hit & ~w_wr_tmr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psc <= 3'd0;
    end else if (w_wr_tmr) begin
      r_psc <= 3'd0;
    end else if (w_inc_en) begin
      r_psc <= w_psc_hit ? 3'd0 : r_psc + 3'd1;
    end
  end

  // A byte write beats a same-cycle increment; the other byte is left alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr1 <= 16'h0000;
    end else if (w_wr_l) begin
      r_tmr1[7:0] <= data_in;
    end else if (w_wr_h) begin
      r_tmr1[15:8] <= data_in;
    end else if (w_tmr_inc) begin
      r_tmr1 <= r_tmr1 + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t1con <= '0;
    end else if (w_wr_c) begin
      r_t1con <= data_in[T1CON_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_tmr_inc & (r_tmr1 == 16'hFFFF);
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (w_sel_l) begin
      data_out = r_tmr1[7:0];
    end else if (w_sel_h) begin
      data_out = r_tmr1[15:8];
    end else if (w_sel_c) begin
      data_out = {2'b00, r_t1con};
    end
  end

  assign rd_hit        = w_sel_l | w_sel_h | w_sel_c;
  assign tmr1if_strobe = r_strobe;

endmodule

// File: tb/tb_timer1_peripheral.sv
// Directed and randomized checks of timer1_peripheral against an arithmetic reference model.
module tb_timer1_peripheral;

  localparam logic [8:0] A_L = 9'h00E;
  localparam logic [8:0] A_H = 9'h00F;
  localparam logic [8:0] A_C = 9'h010;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       clkout  = 1'b0;
  logic       t1cki   = 1'b0;
  logic       wr_en   = 1'b0;
  logic [8:0] addr    = 9'h000;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       rd_hit;
  logic       tmr1if_strobe;

  timer1_peripheral dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clkout        (clkout),
    .t1cki         (t1cki),
    .addr          (addr),
    .data_in       (data_in),
    .wr_en         (wr_en),
    .data_out      (data_out),
    .rd_hit        (rd_hit),
    .tmr1if_strobe (tmr1if_strobe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: counter value, prescale count, control byte, pin histories.
  int m_tmr;
  int m_psc;
  int m_t1con;
  bit m_strobe;
  bit m_clk_prev;
  bit t1_hist[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [8:0] a);
    if (a == A_L) return 16'(m_tmr % 256);
    if (a == A_H) return 16'(m_tmr / 256);
    if (a == A_C) return 16'(m_t1con);
    return 16'h0000;
  endfunction

  function automatic logic [15:0] exp_hit(input logic [8:0] a);
    return {15'b0, (a == A_L) || (a == A_H) || (a == A_C)};
  endfunction

  task automatic model_reset();
    m_tmr = 0; m_psc = 0; m_t1con = 0; m_strobe = 0; m_clk_prev = 0;
    t1_hist = {};
    repeat (3) t1_hist.push_back(1'b0);
  endtask

  // One clock edge of the timer, computed from the register-level rules.
  task automatic model_edge();
    bit wr_l, wr_h, wr_c, rise_c, rise_t, tick, inc;
    int ratio;
    wr_l = wr_en && addr == A_L;
    wr_h = wr_en && addr == A_H;
    wr_c = wr_en && addr == A_C;
    rise_c = clkout && !m_clk_prev;
    m_clk_prev = clkout;
    // t1_hist holds the pin as sampled 3, 2 and 1 edges ago.
    rise_t = t1_hist[1] && !t1_hist[0];
    void'(t1_hist.pop_front());
    t1_hist.push_back(t1cki);
    ratio = 1 << ((m_t1con / 16) % 4);
    tick = (m_t1con & 2) != 0 ? rise_t : rise_c;
    inc = 0;
    if (tick && (m_t1con & 1) != 0) begin
      if (m_psc == ratio - 1) begin
        m_psc = 0;
        inc = 1;
      end else begin
        m_psc = (m_psc + 1) % 8;
      end
    end
    if (wr_l || wr_h) begin
      m_psc = 0;
      inc = 0;
      if (wr_l) m_tmr = (m_tmr / 256) * 256 + int'(data_in);
      else      m_tmr = (m_tmr % 256) + int'(data_in) * 256;
    end
    m_strobe = inc && m_tmr == 65535;
    if (inc) m_tmr = (m_tmr + 1) % 65536;
    if (wr_c) m_t1con = int'(data_in) % 64;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("strobe", {15'b0, tmr1if_strobe}, {15'b0, m_strobe});
    chk("rd_data", {8'h00, data_out}, exp_read(addr));
    chk("rd_hit", {15'b0, rd_hit}, exp_hit(addr));
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    addr = a; data_in = d; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic tmr_is(input string tag, input logic [15:0] exp);
    logic [8:0] save;
    logic [7:0] lo;
    save = addr;
    addr = A_L; #1; lo = data_out;
    addr = A_H; #1;
    chk(tag, {data_out, lo}, exp);
    addr = save;
  endtask

  task automatic check_regs(input string tag);
    logic [8:0] save;
    logic [8:0] list [4];
    save = addr;
    list = '{A_L, A_H, A_C, 9'h08E};
    foreach (list[i]) begin
      addr = list[i]; #1;
      chk(tag, {8'h00, data_out}, exp_read(addr));
      chk(tag, {15'b0, rd_hit}, exp_hit(addr));
    end
    addr = save;
  endtask

  task automatic clk_tick();
    clkout = 1'b1; step();
    clkout = 1'b0; step();
  endtask

  initial begin
    logic [8:0] rnd_addr [6];
    int sc;
    rnd_addr = '{A_L, A_H, A_C, 9'h08E, 9'h011, 9'h00D};
    model_reset();

    // Reset values, including the bank-1 alias that must not decode.
    #2;
    check_regs("reset_regs");
    chk("reset_strobe", {15'b0, tmr1if_strobe}, 16'h0000);
    addr = 9'h08E; #1;
    chk("no_mirror_hit", {15'b0, rd_hit}, 16'h0000);
    chk("no_mirror_data", {8'h00, data_out}, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // clkout source, ratio 1, one clkout rise every 4 clk.
    wr(A_C, 8'h01);
    for (int i = 0; i < 10; i++) begin
      clkout = 1'b0; step(); step();
      clkout = 1'b1; step(); step();
    end
    clkout = 1'b0;
    tmr_is("count10", 16'h000A);
    step();

    // 1:8 prescale from 0xFFFF: seven ticks hold, the eighth wraps with one strobe.
    wr(A_C, 8'h31);
    wr(A_L, 8'hFF);
    wr(A_H, 8'hFF);
    for (int i = 0; i < 7; i++) clk_tick();
    tmr_is("psc8_hold", 16'hFFFF);
    sc = 0;
    clkout = 1'b1; step();
    chk("wrap_strobe_hi", {15'b0, tmr1if_strobe}, 16'h0001);
    if (tmr1if_strobe) sc++;
    clkout = 1'b0; step();
    chk("wrap_strobe_lo", {15'b0, tmr1if_strobe}, 16'h0000);
    if (tmr1if_strobe) sc++;
    step();
    if (tmr1if_strobe) sc++;
    chk("wrap_strobe_count", 16'(sc), 16'h0001);
    tmr_is("wrap_value", 16'h0000);

    // Mid-count write to TMR1L discards the five accumulated prescale ticks.
    for (int i = 0; i < 5; i++) clk_tick();
    wr(A_L, 8'h40);
    for (int i = 0; i < 7; i++) clk_tick();
    tmr_is("psc_clr_hold", 16'h0040);
    clk_tick();
    tmr_is("psc_clr_inc", 16'h0041);

    // TMR1H write colliding with an increment at 0x00FF.
    wr(A_C, 8'h01);
    wr(A_L, 8'hFF);
    wr(A_H, 8'h00);
    clkout = 1'b1;
    wr(A_H, 8'h12);
    chk("wr_wins_nostrobe", {15'b0, tmr1if_strobe}, 16'h0000);
    tmr_is("wr_wins", 16'h12FF);
    clkout = 1'b0; step();

    // T1CKI source: three-edge latency, then gating by TMR1ON.
    wr(A_C, 8'h03);
    t1cki = 1'b1;
    step(); step();
    tmr_is("t1_lat2", 16'h12FF);
    step();
    tmr_is("t1_lat3", 16'h1300);
    t1cki = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      #($urandom_range(0, 3));
      t1cki = 1'b1; repeat (3) step();
      t1cki = 1'b0; repeat (3) step();
    end
    tmr_is("t1_count", 16'h1304);
    wr(A_C, 8'h02);
    for (int i = 0; i < 2; i++) begin
      t1cki = 1'b1; repeat (3) step();
      t1cki = 1'b0; repeat (3) step();
    end
    tmr_is("t1_frozen", 16'h1304);
    t1cki = 1'b1;
    repeat (4) step();
    wr(A_C, 8'h03);
    repeat (4) step();
    tmr_is("t1_reenable", 16'h1304);
    t1cki = 1'b0;
    step();

    // Randomized traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        wr_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("arst_regs");
        chk("arst_strobe", {15'b0, tmr1if_strobe}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("release_nostrobe", {15'b0, tmr1if_strobe}, 16'h0000);
      end
      #($urandom_range(0, 3));
      clkout = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) t1cki = ~t1cki;
      addr = rnd_addr[$urandom_range(0, 5)];
      wr_en = ($urandom_range(0, 7) == 0);
      data_in = 8'($urandom);
      if (addr == A_C) data_in[0] = ($urandom_range(0, 3) != 0);
      else if ($urandom_range(0, 1) == 0) data_in = 8'hFF;
      step();
      if (i % 50 == 0) check_regs("rand_regs");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
